// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter that loads one requester's data into a shared register bank
module dff_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
    state_t state;
    logic [IW-1:0] ptr, sel, win, nxt;
    logic [3:0] cnt;
    always_comb begin
        win = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) win = IW'((int'(ptr) + i) % NREQ);
        end
        nxt = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            owner <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        gnt   <= NREQ'(1) << win;
                        sel   <= win;
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    q     <= wdata[sel*WIDTH +: WIDTH];
                    owner <= sel;
                    ack   <= NREQ'(1) << sel;
                    gnt   <= '0;
                    ptr   <= nxt;
                    cnt   <= 4'(HOLD_CYCLES);
                    state <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
                    busy  <= (HOLD_CYCLES != 0);
                end
                HOLD: begin
                    ack <= '0;
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed vector table plus reset and abort sequences
module tb_dff_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt, ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;
    int checks = 0;
    int fails = 0;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic [7:0] q;
        logic [1:0] owner;
        logic       busy;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                             input logic [7:0] eq, input logic [1:0] eo, input logic eb);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".ack"}, 32'(ack), 32'(ea));
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".owner"}, 32'(owner), 32'(eo));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    // one-hot and ack-follows-grant invariants sampled mid-cycle
    logic [3:0] gnt_prev = '0;
    always @(negedge clk) begin
        check("onehot_gnt", 32'($onehot0(gnt)), 32'd1);
        check("onehot_ack", 32'($onehot0(ack)), 32'd1);
        check("ack_after_gnt", 32'(ack & ~gnt_prev), 32'd0);
        gnt_prev = gnt;
    end

    function automatic vec_t v(logic [3:0] r, logic [3:0] g, logic [3:0] a,
                               logic [7:0] qq, logic [1:0] o, logic b);
        vec_t t;
        t.req = r; t.gnt = g; t.ack = a; t.q = qq; t.owner = o; t.busy = b;
        return t;
    endfunction

    initial begin
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0));
        vecs.push_back(v(4'b0100, 4'b0100, 4'b0000, 8'h00, 2'd0, 1'b1));
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0));
        vecs.push_back(v(4'b0011, 4'b0001, 4'b0000, 8'hA5, 2'd2, 1'b1));
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0001, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b0010, 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b0010, 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b0));
        vecs.push_back(v(4'b0010, 4'b0010, 4'b0000, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b0010, 4'b0000, 4'b0010, 8'h5A, 2'd1, 1'b1));
        vecs.push_back(v(4'b1000, 4'b0000, 4'b0000, 8'h5A, 2'd1, 1'b1));
        vecs.push_back(v(4'b1000, 4'b0000, 4'b0000, 8'h5A, 2'd1, 1'b0));
        vecs.push_back(v(4'b1000, 4'b1000, 4'b0000, 8'h5A, 2'd1, 1'b1));
        vecs.push_back(v(4'b1000, 4'b0000, 4'b1000, 8'h3C, 2'd3, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'h3C, 2'd3, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'h3C, 2'd3, 1'b0));
        vecs.push_back(v(4'b1111, 4'b0001, 4'b0000, 8'h3C, 2'd3, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0001, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b1110, 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b0));
        vecs.push_back(v(4'b1111, 4'b0010, 4'b0000, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0010, 8'h5A, 2'd1, 1'b1));
        vecs.push_back(v(4'b1101, 4'b0000, 4'b0000, 8'h5A, 2'd1, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0000, 8'h5A, 2'd1, 1'b0));
        vecs.push_back(v(4'b1111, 4'b0100, 4'b0000, 8'h5A, 2'd1, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1));
        vecs.push_back(v(4'b1011, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0));
        vecs.push_back(v(4'b1111, 4'b1000, 4'b0000, 8'hA5, 2'd2, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b1000, 8'h3C, 2'd3, 1'b1));
        vecs.push_back(v(4'b0111, 4'b0000, 4'b0000, 8'h3C, 2'd3, 1'b1));
        vecs.push_back(v(4'b1111, 4'b0000, 4'b0000, 8'h3C, 2'd3, 1'b0));
        vecs.push_back(v(4'b1111, 4'b0001, 4'b0000, 8'h3C, 2'd3, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0001, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b1));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b0));

        rst = 1'b0;
        req = '0;
        wdata = {8'h3C, 8'hA5, 8'h5A, 8'h0F};
        #12;
        check_all("reset", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            req = vecs[i].req;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].q,
                      vecs[i].owner, vecs[i].busy);
        end

        // pointer is 1 here: 1,2 idle so 3 wins over 0
        req = 4'b1001;
        @(posedge clk);
        #1;
        check_all("abort_load", 4'b1000, 4'b0000, 8'h0F, 2'd0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_all("abort_async", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check_all("abort_noack", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("restart_ptr0", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        check_all("restart_ack", 4'b0000, 4'b0001, 8'h0F, 2'd0, 1'b1);
        req = 4'b1000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("restart_idle", 4'b0000, 4'b0000, 8'h0F, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check_all("regrant3", 4'b1000, 4'b0000, 8'h0F, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        check_all("regrant3_ack", 4'b0000, 4'b1000, 8'h3C, 2'd3, 1'b1);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Round-robin arbiter and load sequencer for a shared WIDTH-bit D-flip-flop register bank. Up to NREQ requesters compete to write the bank. The block grants one requester at a time, loads that requester's data into the bank, and acknowledges the write. It then enforces a programmable hold window before the next grant, and sits between the requester logic and the shared storage.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, bit width of shared register bank
HOLD_CYCLES, 2, minimum cycles the loaded value is held before next grant (0..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request, level; held until own ack
wdata  input  NREQ*WIDTH  flattened write data; requester i at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-cycle write-done pulse, registered
q  output  WIDTH  shared register bank contents
owner  output  $clog2(NREQ)  index of last requester written
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, ack=0, q=0, owner=0, busy=0, priority pointer=0, hold counter=0.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If req!=0, select winner w = first asserted req scanning from pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - Next edge: gnt[w]=1, state=LOAD, busy=1.
  - If req==0, stay in IDLE with gnt=0.
- LOAD (exactly 1 cycle):
  - On the edge leaving LOAD: q<=wdata[w], owner<=w, ack[w]<=1, gnt<=0, pointer<=(w+1) mod NREQ.
  - Go to HOLD with counter=HOLD_CYCLES, or to IDLE if HOLD_CYCLES=0.
- Timing: latency from req sampled high in IDLE to ack high is 2 edges. q updates on the same edge that ack rises.
- HOLD:
  - ack is high only in the first HOLD cycle and is 0 afterwards.
  - Counter decrements each cycle; at counter==1, next state=IDLE.
  - Requests are ignored during HOLD; no grant is issued.
  - With HOLD_CYCLES=0, ack rises on entry to IDLE. Arbitration in that IDLE cycle proceeds normally, so back-to-back grants are spaced 2 cycles apart.
- Requester rules:
  - A requester drops req in the cycle after it sees ack.
  - The arbiter samples req only in IDLE.
  - req deasserted during LOAD does not abort; the write completes with wdata sampled at the LOAD edge.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 other grants.
- gnt and ack are never multi-hot. ack[i] is asserted only if gnt[i] was asserted in the previous cycle.
- q holds its value whenever no LOAD is in progress, including while the block is idle or in HOLD.
- Reset mid-operation (any state): all outputs return to reset values immediately. No ack is issued for an interrupted grant, and the pointer returns to 0.
- Pointer wrap: after w=NREQ-1, pointer=0.

Test Plan:
- Reset: drive rst=0 asynchronously mid-cycle -> q=0, gnt=0, ack=0, busy=0 before the next edge.
- Single request: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 after edge 1; q=8'hA5, ack=4'b0100, owner=2 after edge 2; busy low after 2 HOLD cycles.
- Round-robin: req=4'b1111 held, with each requester dropping req after its ack and re-raising it -> grant order 0,1,2,3,0. Each grant is spaced LOAD+HOLD+IDLE = 4 cycles apart.
- Pointer wrap and skip: pointer=3 (last winner 2), req=4'b0011 -> grant goes to 0, then 1.
- Request during HOLD: req[1] rises in the first HOLD cycle -> no gnt until IDLE, then gnt=4'b0010. q keeps its prior value throughout HOLD.
- Abort: assert rst=0 while in LOAD with gnt[3]=1 -> no ack, q=0. After release, req[3] still high -> fresh grant to 3 with pointer restarted at 0.
